div_seq_param: RTL and testbench
================================

// Module: div_seq_param
// PURPOSE
//  Parametrised multi-cycle restoring divider; successor to the fixed 32-bit unsigned DIVU.
//  Adds per-operation signed/unsigned mode, a done pulse and divide-by-zero detection.
//  Sits beside the ALU as the long-latency DIV/DIVU/REM/REMU unit and is driven by the pipeline stall logic.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>= 2)
// PORTS
//  clock      in   1      rising-edge clock, the only clock
//  reset      in   1      synchronous, active-high reset
//  start      in   1      request; sampled on the edge where busy=0
//  is_signed  in   1      1: two's-complement operation, 0: unsigned; captured with start
//  dividend   in   WIDTH  captured with start
//  divisor    in   WIDTH  captured with start
//  q          out  WIDTH  quotient, registered; holds until the next done
//  r          out  WIDTH  remainder, registered; holds until the next done
//  busy       out  1      high from the capture edge until the result edge
//  done       out  1      one-cycle pulse; q/r/div_zero are valid when it is high
//  div_zero   out  1      registered with done; 1 means divisor==0
// BEHAVIOUR
//  - Clocking: one clock. Reset is synchronous and active-high.
//  - Reset: on reset=1 at an edge, q=0, r=0, busy=0, done=0, div_zero=0, FSM=IDLE, count=0.
//    - Reset takes priority over every other event, including mid-operation.
//    - A mid-operation reset aborts the division, and no done pulse follows.
//  - FSM IDLE -> CALC -> FIX -> IDLE. Divide-by-zero path: IDLE -> FIX.
//  - IDLE: on an edge with start=1, latch is_signed, the sign bits and the operand magnitudes.
//    - Magnitude = two's-complement negation when is_signed and the MSB is 1.
//    - Set busy=1. Go to CALC with count=WIDTH, or to FIX if divisor==0.
//  - CALC: one restoring step per edge.
//    - Shift {rem,quo} left 1. Trial = rem - divisor magnitude, computed WIDTH+1 bits wide.
//    - If trial >= 0: rem=trial and quo LSB=1; otherwise quo LSB=0.
//    - count decrements each edge. Leave for FIX after exactly WIDTH steps.
//  - FIX: write q and r, pulse done=1, clear busy, return to IDLE.
//    - Signed quotient is negated iff the operand signs differ (truncate toward zero).
//    - Signed remainder takes the sign of the dividend.
//    - Unsigned results are written unchanged.
//  - Latency: done is high in the cycle after WIDTH+2 edges, counting the capture edge.
//    - WIDTH=32 gives 34 edges.
//    - Divide-by-zero completes in 2 edges.
//  - start while busy=1 is ignored; operands are not re-sampled.
//  - Back-to-back: busy=0 in the done cycle, so a start held high is accepted on the next edge.
//  - Divide-by-zero: q = all ones, r = dividend unchanged, div_zero=1. Holds in both modes.
//  - Signed overflow (most-negative / -1): q = most-negative value, r = 0, div_zero=0.
//    - No exception is raised. The result falls out of the magnitude datapath naturally.
//  - Operand inputs may change freely after the capture edge.
//  - div_zero is cleared on the result edge of the next non-zero division.
// TESTING
//  1 Unsigned 7FFFFFFF / FFFFFFFF, start for 1 cycle after reset
//    -> done after 34 edges, q=00000000, r=7FFFFFFF, div_zero=0.
//  2 AAAAAAAA / 7FFFFFFF, run once unsigned then once signed
//    -> unsigned: q=00000001, r=2AAAAAAB; signed: q=00000000, r=AAAAAAAA.
//  3 Signed FFFFFFF9 / 00000002 (-7/2) -> q=FFFFFFFD (-3), r=FFFFFFFF (-1).
//    Signed 80000000 / FFFFFFFF -> q=80000000, r=00000000, div_zero=0.
//  4 Unsigned 00001234 / 00000000 -> done 2 edges after capture,
//    q=FFFFFFFF, r=00001234, div_zero=1. The next valid division clears div_zero.
//  5 Start a division, pulse start again at edge 10 with different operands
//    -> ignored, first result unchanged. Hold start high through done
//    -> second op captured on the edge after the done cycle.
//  6 reset=1 for 1 edge at edge 15 of a division
//    -> all outputs 0 on the next cycle, no done pulse, next start runs normally.
//  Also rerun cases 1 and 3 with WIDTH=8 (e.g. F9/02 signed -> q=FD, r=FF, 10 edges).

Source files
------------

// File: rtl/div_seq_param.sv
// -----------------------------------------------------------------------------
// div_seq_param
//
// Multi-cycle restoring divider for the DIV/DIVU/REM/REMU unit beside the ALU.
// Each operation chooses signed (two's-complement) or unsigned mode. The
// divider works on operand magnitudes and fixes up the result signs in a
// final cycle. A zero divisor skips the iteration entirely.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 2)
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   start      operation request, accepted only on an edge where busy=0
//   is_signed  1: signed operation, 0: unsigned (captured with start)
//   dividend   dividend operand (captured with start)
//   divisor    divisor operand (captured with start)
//   q          quotient, registered, holds until the next done
//   r          remainder, registered, holds until the next done
//   busy       high from the capture edge until the result edge
//   done       one-cycle pulse; q, r and div_zero are valid while it is high
//   div_zero   registered with done; 1 means the divisor was zero
//
// Handshake: start is a request qualified by busy=0. The operands are taken on
// that edge. busy then stays high until the result edge, and start is ignored
// for that whole time. done pulses for exactly one cycle, and busy is already
// low in that cycle. A start held high is therefore accepted on the edge that
// follows the done cycle.
//
// Latency: capture edge + WIDTH iteration edges + 1 fix-up edge. done is high
// in the cycle after edge WIDTH+2. A zero divisor takes 2 edges.
// -----------------------------------------------------------------------------
module div_seq_param #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;       // partial remainder; holds the raw dividend on the zero path
  logic [WIDTH-1:0] quo;       // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dmag;      // divisor magnitude
  logic             neg_q;     // quotient must be negated at fix-up
  logic             neg_r;     // remainder must be negated at fix-up
  logic             dz;        // operation has a zero divisor

  // Operand magnitudes. For the most-negative value the negation returns the
  // same bit pattern. Read as unsigned, that pattern is the correct magnitude.
  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;

  always_comb begin
    dividend_mag = dividend;
    divisor_mag  = divisor;
    if (is_signed && dividend[WIDTH-1]) dividend_mag = -dividend;
    if (is_signed && divisor[WIDTH-1])  divisor_mag  = -divisor;
  end

  // One restoring step. The shifted remainder can need WIDTH+1 bits, because
  // the divisor magnitude may be as large as 2^WIDTH-1. The subtraction gets
  // one more bit for the sign, and the MSB of trial is the borrow.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  always_comb begin
    shifted = {1'b0, rem, quo[WIDTH-1]};
    trial   = shifted - {2'b00, dmag};
  end

  // Sign fix-up of the magnitude results. This truncates toward zero, and the
  // remainder takes the sign of the dividend. Most-negative / -1 gives a
  // quotient magnitude of 2^(WIDTH-1), and that is left unchanged here.
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    q_fix = quo;
    r_fix = rem;
    if (neg_q) q_fix = -quo;
    if (neg_r) r_fix = -rem;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
      dmag     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz       <= 1'b0;
      q        <= '0;
      r        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            neg_q <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= is_signed & dividend[WIDTH-1];
            quo   <= dividend_mag;
            dmag  <= divisor_mag;
            count <= CW'(WIDTH);
            if (divisor == '0) begin
              // r must come back as the untouched dividend, so keep it raw.
              dz    <= 1'b1;
              rem   <= dividend;
              state <= FIX;
            end else begin
              dz    <= 1'b0;
              rem   <= '0;
              state <= CALC;
            end
          end
        end

        CALC: begin
          if (!trial[WIDTH+1]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          count <= count - CW'(1);
          if (count == CW'(1)) state <= FIX;
        end

        FIX: begin
          if (dz) begin
            q        <= '1;
            r        <= rem;
            div_zero <= 1'b1;
          end else begin
            q        <= q_fix;
            r        <= r_fix;
            div_zero <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_param.sv
module tb_div_seq_param;

  // ---------------------------------------------------------------- clock/reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // 32-bit instance
  logic        start32 = 1'b0, sg32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [31:0] q32, r32;
  logic        busy32, done32, dz32;

  // 8-bit instance
  logic        start8 = 1'b0, sg8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [7:0]  q8, r8;
  logic        busy8, done8, dz8;

  div_seq_param #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .start(start32), .is_signed(sg32),
    .dividend(a32), .divisor(b32), .q(q32), .r(r32),
    .busy(busy32), .done(done32), .div_zero(dz32)
  );

  div_seq_param #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .is_signed(sg8),
    .dividend(a8), .divisor(b8), .q(q8), .r(r8),
    .busy(busy8), .done(done8), .div_zero(dz8)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_r[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model written as plain integer arithmetic. SystemVerilog integer
  // division truncates toward zero, and % takes the sign of the dividend.
  function automatic void model(input bit w8, input bit sg, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] eq,
                                output logic [31:0] er, output bit edz);
    int w;
    longint m, ua, ub, sa, sb, qq, rr;
    w  = w8 ? 8 : 32;
    m  = (longint'(1) << w) - 1;
    ua = longint'({32'b0, a}) & m;
    ub = longint'({32'b0, b}) & m;
    if (ub == 0) begin
      eq = 32'(m); er = 32'(ua); edz = 1'b1;
    end else begin
      edz = 1'b0;
      if (sg) begin
        sa = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
        sb = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
        qq = sa / sb;
        rr = sa % sb;
      end else begin
        qq = ua / ub;
        rr = ua % ub;
      end
      eq = 32'(qq & m);
      er = 32'(rr & m);
    end
  endfunction

  // ---------------------------------------------------------------- driver
  // Entered and left at #1 after a rising edge, with the chosen DUT idle.
  // lat counts edges from the capture edge (1) to the edge after which done is seen.
  task automatic do_op(input bit w8, input bit sg, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] qo, output logic [31:0] ro, output bit dzo,
                       output int lat, output bit busy_cap);
    if (w8) begin start8 = 1'b1; sg8 = sg; a8 = a[7:0]; b8 = b[7:0]; end
    else    begin start32 = 1'b1; sg32 = sg; a32 = a; b32 = b; end
    @(posedge clock); #1;
    busy_cap = w8 ? busy8 : busy32;
    start8 = 1'b0; start32 = 1'b0;
    // Operands may change freely after capture.
    a8 = 8'($urandom); b8 = 8'($urandom); a32 = $urandom; b32 = $urandom;
    lat = 1;
    while (!(w8 ? done8 : done32) && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    qo  = w8 ? {24'b0, q8} : q32;
    ro  = w8 ? {24'b0, r8} : r32;
    dzo = w8 ? dz8 : dz32;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    bit          w8;
    bit          sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eq;
    logic [31:0] er;
    bit          edz;
    int          elat;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic [31:0] qo, ro, eq, er, a, b;
    bit dzo, edz, bc, w8, sg;
    int lat, ndone;

    vecs[0]  = '{1'b0, 1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h7FFFFFFF, 1'b0, 34};
    vecs[1]  = '{1'b0, 1'b0, 32'hAAAAAAAA, 32'h7FFFFFFF, 32'h00000001, 32'h2AAAAAAB, 1'b0, 34};
    vecs[2]  = '{1'b0, 1'b1, 32'hAAAAAAAA, 32'h7FFFFFFF, 32'h00000000, 32'hAAAAAAAA, 1'b0, 34};
    vecs[3]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34};
    vecs[4]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 34};
    vecs[5]  = '{1'b0, 1'b0, 32'h00001234, 32'h00000000, 32'hFFFFFFFF, 32'h00001234, 1'b1, 2};
    vecs[6]  = '{1'b0, 1'b0, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 1'b0, 34};
    vecs[7]  = '{1'b0, 1'b1, 32'h80000005, 32'h00000000, 32'hFFFFFFFF, 32'h80000005, 1'b1, 2};
    vecs[8]  = '{1'b0, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 34};
    vecs[9]  = '{1'b1, 1'b1, 32'h000000F9, 32'h00000002, 32'h000000FD, 32'h000000FF, 1'b0, 10};
    vecs[10] = '{1'b1, 1'b0, 32'h0000007F, 32'h000000FF, 32'h00000000, 32'h0000007F, 1'b0, 10};
    vecs[11] = '{1'b1, 1'b1, 32'h00000080, 32'h000000FF, 32'h00000080, 32'h00000000, 1'b0, 10};
    vecs[12] = '{1'b1, 1'b1, 32'h000000F0, 32'h00000000, 32'h000000FF, 32'h000000F0, 1'b1, 2};
    vecs[13] = '{1'b1, 1'b0, 32'h000000FF, 32'h00000001, 32'h000000FF, 32'h00000000, 1'b0, 10};

    // ---- reset state
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_q", q32, 32'h0);
    chk("reset_r", r32, 32'h0);
    chk("reset_busy", {31'b0, busy32}, 32'h0);
    chk("reset_done", {31'b0, done32}, 32'h0);
    chk("reset_dz", {31'b0, dz32}, 32'h0);
    chk("reset_busy8", {31'b0, busy8}, 32'h0);
    reset = 1'b0;
    @(posedge clock); #1;

    // ---- directed table
    foreach (vecs[i]) begin
      do_op(vecs[i].w8, vecs[i].sg, vecs[i].a, vecs[i].b, qo, ro, dzo, lat, bc);
      chk($sformatf("vec%0d_q", i), qo, vecs[i].eq);
      chk($sformatf("vec%0d_r", i), ro, vecs[i].er);
      chk($sformatf("vec%0d_dz", i), {31'b0, dzo}, {31'b0, vecs[i].edz});
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].elat);
      chk($sformatf("vec%0d_busy", i), {31'b0, bc}, 32'h1);
      @(posedge clock); #1;
      chk($sformatf("vec%0d_done_pulse", i), {31'b0, (vecs[i].w8 ? done8 : done32)}, 32'h0);
    end

    // ---- div_zero holds through the next operation and clears on its result edge
    do_op(1'b0, 1'b0, 32'd9, 32'd0, qo, ro, dzo, lat, bc);
    chk("dzseq_first", {31'b0, dzo}, 32'h1);
    start32 = 1'b1; sg32 = 1'b0; a32 = 32'd50; b32 = 32'd5;
    @(posedge clock); #1;
    start32 = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("dzseq_hold", {31'b0, dz32}, 32'h1);
    lat = 0;
    while (!done32 && lat < 200) begin @(posedge clock); #1; lat++; end
    chk("dzseq_clear", {31'b0, dz32}, 32'h0);
    chk("dzseq_q", q32, 32'd10);
    @(posedge clock); #1;

    // ---- start while busy is ignored; a start held through done is taken next
    start32 = 1'b1; sg32 = 1'b0; a32 = 32'd100; b32 = 32'd7;
    @(posedge clock); #1;
    start32 = 1'b0;
    lat = 1;
    repeat (8) begin @(posedge clock); #1; lat++; end
    a32 = 32'hFFFF0000; b32 = 32'h00000010; start32 = 1'b1;
    while (!done32 && lat < 200) begin @(posedge clock); #1; lat++; end
    chk("busyign_lat", lat, 34);
    chk("busyign_q", q32, 32'd14);
    chk("busyign_r", r32, 32'd2);
    chk("busyign_busy_at_done", {31'b0, busy32}, 32'h0);
    @(posedge clock); #1;
    chk("b2b_capture", {31'b0, busy32}, 32'h1);
    start32 = 1'b0; a32 = $urandom; b32 = $urandom;
    lat = 1;
    while (!done32 && lat < 200) begin @(posedge clock); #1; lat++; end
    chk("b2b_lat", lat, 34);
    chk("b2b_q", q32, 32'h0FFFF000);
    chk("b2b_r", r32, 32'h0);
    @(posedge clock); #1;

    // ---- mid-operation reset
    start32 = 1'b1; sg32 = 1'b0; a32 = 32'hDEADBEEF; b32 = 32'd3;
    @(posedge clock); #1;
    start32 = 1'b0;
    repeat (13) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("midrst_q", q32, 32'h0);
    chk("midrst_r", r32, 32'h0);
    chk("midrst_busy", {31'b0, busy32}, 32'h0);
    chk("midrst_done", {31'b0, done32}, 32'h0);
    chk("midrst_dz", {31'b0, dz32}, 32'h0);
    ndone = 0;
    repeat (40) begin @(posedge clock); #1; if (done32) ndone++; end
    chk("midrst_no_done", ndone, 0);
    model(1'b0, 1'b0, 32'hDEADBEEF, 32'd3, eq, er, edz);
    do_op(1'b0, 1'b0, 32'hDEADBEEF, 32'd3, qo, ro, dzo, lat, bc);
    chk("postrst_q", qo, eq);
    chk("postrst_r", ro, er);
    chk("postrst_lat", lat, 34);
    @(posedge clock); #1;

    // ---- randomized operations against the reference model
    for (int i = 0; i < 160; i++) begin
      w8 = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       a = w8 ? 32'h80 : 32'h80000000;
        1:       a = 32'hFFFFFFFF;
        default: a = $urandom >> $urandom_range(0, 31);
      endcase
      case ($urandom_range(0, 9))
        0:       b = 32'h0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'h1;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      model(w8, sg, a, b, eq, er, edz);
      exp_q.push_back(eq);
      exp_r.push_back(er);
      do_op(w8, sg, a, b, qo, ro, dzo, lat, bc);
      chk($sformatf("rnd%0d_q", i), qo, exp_q.pop_front());
      chk($sformatf("rnd%0d_r", i), ro, exp_r.pop_front());
      chk($sformatf("rnd%0d_dz", i), {31'b0, dzo}, {31'b0, edz});
      chk($sformatf("rnd%0d_lat", i), lat, edz ? 2 : (w8 ? 10 : 34));
      @(posedge clock); #1;
    end

    // ---- final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
